// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Per-digit ceiling, least significant digit (sec ones) in [3:0].
    localparam logic [15:0] DIGIT_MAX = {BCD_MAX, BCD_MAX, SEC_TENS_MAX, BCD_MAX};

    function automatic logic [15:0] bcd_clamp16(input logic [15:0] value);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = (value[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ?
                            DIGIT_MAX[i*4 +: 4] : value[i*4 +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the button logic, the countdown timer and the display mux.
interface countdown_timer_if;
    logic        load;
    logic [15:0] load_value;
    logic        start_stop;
    logic [15:0] digits;
    logic        running;
    logic        alarm;
    logic        done;

    modport master (
        output load, load_value, start_stop,
        input  digits, running, alarm, done
    );

    modport slave (
        input  load, load_value, start_stop,
        output digits, running, alarm, done
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of a borrow-chained decrementer; wraps 0 to max when borrowing.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);
    assign borrow_out = borrow_in && (digit == 4'd0);
    assign next_digit = !borrow_in      ? digit :
                        (digit == 4'd0) ? max   : digit - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with IDLE/RUN/PAUSE/ALARM control.
// Define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value instead of alarming.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter  int CLK_DIV = 50_000_000,
    localparam int PW      = $clog2(CLK_DIV)
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    state_t         state;
    logic [PW-1:0]  prescaler;
    logic [15:0]    digits_q;
    logic           done_q;
    logic [15:0]    stepped;
    logic [4:0]     borrow;
    logic           tick;
    logic           reach_zero;

    assign tick = (state == RUN) && (prescaler == PW'(CLK_DIV - 1));

    assign borrow[0] = 1'b1;
    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_down u_dig (
            .digit      (digits_q[g*4 +: 4]),
            .max        (DIGIT_MAX[g*4 +: 4]),
            .borrow_in  (borrow[g]),
            .next_digit (stepped[g*4 +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // A borrow out of the top digit would mean stepping from 0000; treat it as terminal too.
    assign reach_zero = (stepped == 16'h0000) || borrow[4];

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [15:0] reload_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            reload_q <= '0;
        else if (bus.load && state != RUN)
            reload_q <= bcd_clamp16(bus.load_value);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            digits_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load && state != RUN) begin
                digits_q  <= bcd_clamp16(bus.load_value);
                prescaler <= '0;
                state     <= IDLE;
            end else if (bus.start_stop) begin
                // Prescaler is untouched here so a pause/resume keeps its phase.
                case (state)
                    IDLE:    if (digits_q != 16'h0000) state <= RUN;
                    RUN:     state <= PAUSE;
                    PAUSE:   state <= RUN;
                    ALARM:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state == RUN) begin
                if (tick) begin
                    prescaler <= '0;
                    if (reach_zero) begin
                        done_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (reload_q != 16'h0000) begin
                            digits_q <= reload_q;
                        end else begin
                            digits_q <= '0;
                            state    <= ALARM;
                        end
`else
                        digits_q <= '0;
                        state    <= ALARM;
`endif
                    end else begin
                        digits_q <= stepped;
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = (state == RUN);
    assign bus.alarm   = (state == ALARM);
    assign bus.done    = done_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown companion to the stopwatch up-counter: loads a BCD MM:SS preset and counts it down once per second to 00:00, then raises an alarm.
- Sits beside the stopwatch datapath, driving the same 4-digit 7-segment display mux with packed BCD digits.
- Controlled by debounced single-cycle `load` and `start_stop` pulses from the board buttons.

Parameters:
- CLK_DIV, default 50_000_000, clock cycles per countdown step (1 Hz at 50 MHz); legal values are 2 or greater.
- PW, derived as $clog2(CLK_DIV), prescaler width; not for override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets the block immediately).
- load  input  1  single-cycle pulse; captures load_value.
- load_value  input  16  packed BCD preset: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- start_stop  input  1  single-cycle pulse; start, pause, resume or acknowledge.
- digits  output  16  current packed BCD MM:SS value.
- running  output  1  high while in RUN.
- alarm  output  1  high while in ALARM.
- done  output  1  one-cycle pulse on the edge where the value reaches 0000.

Behaviour:
- Reset (reset==0, asynchronous):
  - Outputs: digits=0000, running=0, alarm=0, done=0.
  - Internal: state=IDLE, prescaler=0.
  - Mid-run reset aborts immediately, with no done pulse.
- States: IDLE, RUN, PAUSE, ALARM. Registered Moore outputs:
  - running = (state==RUN)
  - alarm = (state==ALARM)
- Load:
  - Accepted in IDLE, PAUSE and ALARM; ignored in RUN.
  - Next edge: digits = clamped load_value, prescaler=0, state=IDLE, alarm=0.
  - Clamp per digit: any BCD digit above 9 becomes 9; sec tens above 5 becomes 5. Example: 9A7F loads as 9959.
- start_stop transitions:
  - IDLE with digits!=0000 goes to RUN.
  - IDLE with digits==0000 stays in IDLE.
  - RUN goes to PAUSE; the prescaler is held, not cleared.
  - PAUSE goes to RUN, continuing from the held prescaler value.
  - ALARM goes to IDLE, with digits left at 0000.
- load and start_stop in the same cycle: load wins and start_stop is dropped.
- Prescaler:
  - Advances only in RUN and counts 0..CLK_DIV-1.
  - The cycle where it equals CLK_DIV-1 is a tick; it wraps to 0 on the same edge.
  - The first step therefore comes CLK_DIV cycles after the start edge.
- Step on tick:
  - Decrement BCD with borrow.
  - Sec ones 0 becomes 9 and borrows from sec tens.
  - Sec tens 0 becomes 5 and borrows from min ones.
  - Min ones 0 becomes 9 and borrows from min tens.
  - Min tens never underflows, because a step never occurs at 0000.
- Reaching zero:
  - On the edge the step produces 0000: done=1 for exactly that one cycle, and state goes to ALARM on the same edge (running falls, alarm rises).
  - Step latency is 0 cycles: digits, done and state all update on the tick edge.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN
- When defined:
  - A 16-bit reload register holds the last clamped load value; it resets to 0000.
  - On the step that would produce 0000, digits reload from that register instead.
  - done still pulses for one cycle, the state stays in RUN and ALARM is never entered.
  - A zero reload register behaves exactly as without the feature.
- When undefined: no reload register; behaviour is as described above.

Decomposition:
- Package countdown_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3);
  - BCD constants BCD_MAX=4'd9 and SEC_TENS_MAX=4'd5;
  - a function bcd_clamp16.
- Sub-module bcd_digit_down, instantiated four times:
  - Inputs: digit, max, borrow_in.
  - Outputs: next_digit, borrow_out.
  - Purely combinational and chained.
- FSM, prescaler and registers stay in countdown_timer.

Test Plan:
- Reset: hold reset=0 while running with digits=0123 → outputs go to 0000/0/0/0 asynchronously, before the next clk edge. Release, then start_stop with no load → stays in IDLE.
- Borrow chain (CLK_DIV=4): load 0100, start_stop → digits are 0059 after 4 clocks and 0058 after 8. Load 1000 → after one step, 0959.
- Zero reached (CLK_DIV=4): load 0003, start_stop → done high for exactly one cycle at clock 12, digits=0000, alarm=1, running=0. A following start_stop → IDLE with alarm=0.
- Pause (CLK_DIV=4): load 0010, start, pause after 2 clocks, idle 20 clocks → digits stay 0010. Resume → 0009 exactly 2 clocks later.
- Load rules:
  - load 9A7F → digits 9959.
  - load during RUN → ignored, countdown continues.
  - load 0005 with start_stop in the same cycle, from IDLE → digits=0005, state IDLE.
- With COUNTDOWN_AUTORELOAD_EN (CLK_DIV=4): load 0002, start → at clock 8, done pulses and digits=0002, running stays 1, alarm stays 0.
